alu_trace_buffer: RTL



---
 rtl/alu_trace_buffer_pkg.sv | 78 +++++++
 rtl/alu_trace_buffer_if.sv | 31 +++
 rtl/alu_trace_buffer_fifo.sv | 67 ++++++
 rtl/alu_trace_buffer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_trace_buffer_pkg.sv
// Shared definitions for the ALU trace buffer: function codes, classes,
// trigger FSM states and the packed record layout.
package alu_trace_pkg;

  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_SUB = 6'b000001;
  localparam logic [5:0] FN_AND = 6'b011000;
  localparam logic [5:0] FN_OR  = 6'b011110;
  localparam logic [5:0] FN_XOR = 6'b010110;
  localparam logic [5:0] FN_NOR = 6'b010001;
  localparam logic [5:0] FN_A   = 6'b011010;
  localparam logic [5:0] FN_SLL = 6'b100000;
  localparam logic [5:0] FN_SRL = 6'b100001;
  localparam logic [5:0] FN_SRA = 6'b100011;
  localparam logic [5:0] FN_EQ  = 6'b110011;
  localparam logic [5:0] FN_NEQ = 6'b110001;
  localparam logic [5:0] FN_LT  = 6'b110101;
  localparam logic [5:0] FN_LEZ = 6'b111101;
  localparam logic [5:0] FN_GEZ = 6'b111001;
  localparam logic [5:0] FN_GTZ = 6'b111111;

  // Class index is ALUFunc[5:4]; it selects one bit of class_mask.
  typedef enum logic [1:0] {
    CLS_ARITH = 2'd0,
    CLS_LOGIC = 2'd1,
    CLS_SHIFT = 2'd2,
    CLS_CMP   = 2'd3
  } func_class_t;

  typedef enum logic [1:0] {
    ST_CAPTURE   = 2'b00,
    ST_TRIGGERED = 2'b01,
    ST_STOPPED   = 2'b10
  } trace_state_t;

  // Record is {illegal, ts, ALUFunc, Signed, A, B, S}, MSB first.
  function automatic int rec_width(input int data_w, input int ts_w);
    return 1 + ts_w + 6 + 1 + 3 * data_w;
  endfunction

  function automatic int off_s(input int data_w);
    return 0 * data_w;
  endfunction

  function automatic int off_b(input int data_w);
    return data_w;
  endfunction

  function automatic int off_a(input int data_w);
    return 2 * data_w;
  endfunction

  function automatic int off_signed(input int data_w);
    return 3 * data_w;
  endfunction

  function automatic int off_func(input int data_w);
    return 3 * data_w + 1;
  endfunction

  function automatic int off_ts(input int data_w);
    return 3 * data_w + 7;
  endfunction

  function automatic int off_illegal(input int data_w, input int ts_w);
    return 3 * data_w + 7 + ts_w;
  endfunction

  function automatic logic is_legal_func(input logic [5:0] f);
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_A,
      FN_SLL, FN_SRL, FN_SRA,
      FN_EQ, FN_NEQ, FN_LT, FN_LEZ, FN_GEZ, FN_GTZ: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_trace_buffer_if.sv
// Capture and drain signals of the trace buffer; the ALU/debug side is the
// master, the buffer is the slave.
interface alu_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int TS_W   = 16
);
  import alu_trace_pkg::*;

  localparam int REC_W = rec_width(DATA_W, TS_W);

  logic              cap_valid;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] S;
  logic              Signed;
  logic [5:0]        ALUFunc;
  logic              rd_valid;
  logic              rd_ready;
  logic [REC_W-1:0]  rd_data;

  modport master (
    output cap_valid, A, B, S, Signed, ALUFunc, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  cap_valid, A, B, S, Signed, ALUFunc, rd_ready,
    output rd_valid, rd_data
  );

endinterface

// File: rtl/alu_trace_buffer_fifo.sv
// Circular record store with extra-bit pointers and first-word-fall-through
// output; optionally overwrites the oldest entry when full.
module alu_trace_fifo #(
  parameter int WIDTH     = 120,
  parameter int DEPTH     = 16,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop_req,
  output logic                   rd_valid,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
  localparam logic OW = OVERWRITE;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             do_pop;
  logic             do_write;
  logic             discard_oldest;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop         = pop_req & ~empty;
  assign do_write       = push & (~full | do_pop | OW);
  // Overwriting lands on the oldest slot, so the read pointer steps past it.
  assign discard_oldest = push & full & ~do_pop & OW;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop || discard_oldest) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && !clear) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level    = wr_ptr - rd_ptr;

endmodule

// File: rtl/alu_trace_buffer.sv
// ALU transaction tracer: qualifies operations, stamps them, and stores them
// in a circular buffer under control of a pre/post trigger state machine.
module alu_trace_buffer
  import alu_trace_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int TS_W      = 16,
  parameter int POST_CNT  = 8,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_trace_buffer_if.slave      bus,
  input  logic [3:0]             class_mask,
  input  logic                   trig_en,
  input  logic [5:0]             trig_func,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            drop_cnt,
  output logic [1:0]             state
);

  localparam int REC_W       = rec_width(DATA_W, TS_W);
  localparam int PC_W        = $clog2(DEPTH + 1);
  localparam int OFF_S       = off_s(DATA_W);
  localparam int OFF_B       = off_b(DATA_W);
  localparam int OFF_A       = off_a(DATA_W);
  localparam int OFF_SIGNED  = off_signed(DATA_W);
  localparam int OFF_FUNC    = off_func(DATA_W);
  localparam int OFF_TS      = off_ts(DATA_W);
  localparam int OFF_ILLEGAL = off_illegal(DATA_W, TS_W);

  trace_state_t      st;
  logic [TS_W-1:0]   ts;
  logic [PC_W-1:0]   post_left;
  logic              accept;
  logic              trig_hit;
  logic              illegal;
  logic              full;
  logic              pop;
  logic              drop;
  logic [REC_W-1:0]  rec;
  logic              fifo_valid;
  logic [REC_W-1:0]  fifo_data;

  assign accept   = bus.cap_valid & class_mask[bus.ALUFunc[5:4]] & (st != ST_STOPPED);
  assign trig_hit = trig_en & (bus.ALUFunc == trig_func);
  assign illegal  = ~is_legal_func(bus.ALUFunc);
  assign pop      = fifo_valid & bus.rd_ready;
  // A record is lost only when the buffer stays full through this cycle.
  assign drop     = accept & full & ~pop & ~clear;

  always_comb begin
    rec                         = '0;
    rec[OFF_ILLEGAL]            = illegal;
    rec[OFF_TS +: TS_W]         = ts;
    rec[OFF_FUNC +: 6]          = bus.ALUFunc;
    rec[OFF_SIGNED]             = bus.Signed;
    rec[OFF_A +: DATA_W]        = bus.A;
    rec[OFF_B +: DATA_W]        = bus.B;
    rec[OFF_S +: DATA_W]        = bus.S;
  end

  alu_trace_fifo #(
    .WIDTH     (REC_W),
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (accept),
    .push_data (rec),
    .pop_req   (bus.rd_ready),
    .rd_valid  (fifo_valid),
    .rd_data   (fifo_data),
    .level     (level),
    .full      (full)
  );

  assign bus.rd_valid = fifo_valid;
  assign bus.rd_data  = fifo_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  // Dropped records still advance the trigger and post-trigger count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_CAPTURE;
      post_left <= '0;
      drop_cnt  <= '0;
    end else if (clear) begin
      st        <= ST_CAPTURE;
      post_left <= '0;
      drop_cnt  <= '0;
    end else begin
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (accept) begin
        case (st)
          ST_CAPTURE: begin
            if (trig_hit) begin
              if (POST_CNT == 0) begin
                st <= ST_STOPPED;
              end else begin
                st        <= ST_TRIGGERED;
                post_left <= PC_W'(POST_CNT);
              end
            end
          end
          ST_TRIGGERED: begin
            post_left <= post_left - PC_W'(1);
            if (post_left == PC_W'(1)) begin
              st <= ST_STOPPED;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign state = st;

endmodule
